// File: rtl/uart_pkg.sv
// Shared UART definitions: default generator widths and the divisor record
// held in the baud generator's shadow and active registers.
package uart_pkg;

    localparam int UART_DIV_W  = 16;
    localparam int UART_FRAC_W = 4;
    localparam int UART_OSR    = 16;

    typedef struct packed {
        logic [UART_DIV_W-1:0]  int_part;
        logic [UART_FRAC_W-1:0] frac_part;
    } baud_div_t;

endpackage

// File: rtl/uart_baud_gen_frac_core.sv
// Fractional cycle divider: counts clk cycles into oversample periods of
// div_int or div_int+1 cycles so the long-run average is div_int + frac/2^FRAC_W.
module frac_div_core #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              wrap,
    output logic              os_tick
);

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              extra;
    logic              hold;
    logic [DIV_W:0]    period_m1;
    logic [FRAC_W:0]   acc_sum;

    // One extra bit so a full 2^DIV_W period (div_int all ones plus extra) fits.
    assign period_m1 = {1'b0, div_int} + {{DIV_W{1'b0}}, extra} - {{DIV_W{1'b0}}, 1'b1};
    assign acc_sum   = {1'b0, acc} + {1'b0, div_frac};
    assign hold      = ~en | clr | (div_int == '0);
    assign wrap      = ~hold & ({1'b0, cnt} == period_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            extra   <= 1'b0;
            os_tick <= 1'b0;
        end else if (hold) begin
            cnt     <= '0;
            acc     <= '0;
            extra   <= 1'b0;
            os_tick <= 1'b0;
        end else if (wrap) begin
            cnt            <= '0;
            {extra, acc}   <= acc_sum;
            os_tick        <= 1'b1;
        end else begin
            cnt     <= cnt + DIV_W'(1);
            os_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator top: shadow/active divisor handover, oversample
// counting and bit/mid-bit tick decode around the fractional divider core.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W  = UART_DIV_W,
    parameter int FRAC_W = UART_FRAC_W,
    parameter int OSR    = UART_OSR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              sync_clr,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              cfg_err
);

    typedef struct packed {
        logic [DIV_W-1:0]  int_part;
        logic [FRAC_W-1:0] frac_part;
    } div_cfg_t;

    localparam int OS_W = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR / 2);

    div_cfg_t        shadow;
    div_cfg_t        active;
    div_cfg_t        active_next;
    logic            pending;
    logic            apply;
    logic            zero_div;
    logic            wrap;
    logic            os_clr;
    logic [OS_W-1:0] os_cnt;
    logic [OS_W-1:0] os_cnt_inc;

    assign zero_div = (active.int_part == '0);
    // A zero active divisor never wraps, so a pending load must land at once.
    assign apply    = pending & (wrap | ~en | sync_clr | zero_div);

    always_comb begin
        active_next = active;
        if (apply)
            active_next = shadow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            cfg_err <= 1'b1;
        end else begin
            if (div_load)
                shadow <= '{int_part: div_int, frac_part: div_frac};
            active  <= active_next;
            cfg_err <= (active_next.int_part == '0);
            // A load coinciding with an apply stays pending for the next wrap.
            pending <= div_load | (pending & ~apply);
        end
    end

    frac_div_core #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (sync_clr),
        .div_int  (active.int_part),
        .div_frac (active.frac_part),
        .wrap     (wrap),
        .os_tick  (os_tick)
    );

    assign os_clr     = ~en | sync_clr | zero_div;
    assign os_cnt_inc = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt   <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else if (os_clr) begin
            os_cnt   <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else if (wrap) begin
            os_cnt   <= os_cnt_inc;
            bit_tick <= (os_cnt == OS_LAST);
            mid_tick <= (os_cnt_inc == OS_MID);
        end else begin
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac with OSR=4, FRAC_W=4: integer and
// fractional periods, divisor handover, resync, zero divisor, enable, reset.
module tb_uart_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        sync_clr;
    logic        os_tick;
    logic        bit_tick;
    logic        mid_tick;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_baud_gen_frac #(
        .DIV_W  (16),
        .FRAC_W (4),
        .OSR    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .sync_clr (sync_clr),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges from now until os_tick is seen; -1 if it never comes.
    task automatic wait_os(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!os_tick && n < 200);
        if (!os_tick) n = -1;
    endtask

    task automatic capture(input int n, output logic [63:0] ov, output logic [63:0] bv,
                           output logic [63:0] mv);
        ov = '0; bv = '0; mv = '0;
        for (int k = 0; k < n; k++) begin
            step(1);
            ov[k] = os_tick;
            bv[k] = bit_tick;
            mv[k] = mid_tick;
        end
    endtask

    task automatic count_ticks(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            step(1);
            if (os_tick || bit_tick || mid_tick) c++;
        end
    endtask

    task automatic load_idle(input logic [15:0] di, input logic [3:0] df);
        en       = 1'b0;
        div_int  = di;
        div_frac = df;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        step(1);
    endtask

    initial begin
        logic [63:0] ov, bv, mv;
        int n, c, nt;
        int t[32];

        rst_n = 1'b0; en = 1'b0; div_int = '0; div_frac = '0;
        div_load = 1'b0; sync_clr = 1'b0;
        step(2);
        chk("reset_os", os_tick, 1'b0);
        chk("reset_bit", bit_tick, 1'b0);
        chk("reset_mid", mid_tick, 1'b0);
        chk("reset_cfg_err", cfg_err, 1'b1);
        rst_n = 1'b1;

        // No load yet: divisor is zero
        en = 1'b1;
        count_ticks(10, c);
        chk("zero_after_reset_cfg_err", cfg_err, 1'b1);
        chk("zero_after_reset_ticks", c, 0);

        // Integer divisor 3
        load_idle(16'd3, 4'd0);
        chk("int3_cfg_err", cfg_err, 1'b0);
        en = 1'b1;
        capture(24, ov, bv, mv);
        chk("int3_os", ov, 64'h924924);
        chk("int3_bit", bv, 64'h800800);
        chk("int3_mid", mv, 64'h020020);
        chk("int3_no_lone_ticks", (bv | mv) & ~ov, 64'h0);

        // Fractional divisor 3 + 8/16
        load_idle(16'd3, 4'd8);
        en = 1'b1;
        capture(64, ov, bv, mv);
        nt = 0;
        for (int k = 0; k < 64; k++)
            if (ov[k] && nt < 32) begin t[nt] = k + 1; nt++; end
        chk("frac_first", t[0], 3);
        chk("frac_gap1", t[1] - t[0], 3);
        chk("frac_gap2", t[2] - t[1], 4);
        chk("frac_gap3", t[3] - t[2], 3);
        chk("frac_gap4", t[4] - t[3], 4);
        chk("frac_span16", t[16] - t[0], 56);
        chk("frac_no_lone_ticks", (bv | mv) & ~ov, 64'h0);

        // Load mid-period: current period keeps 3, next is 5
        load_idle(16'd3, 4'd0);
        en = 1'b1;
        wait_os(n);
        chk("ld_start", n, 3);
        step(1);
        div_int = 16'd5; div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        wait_os(n);
        chk("ld_mid_old_period", n + 2, 3);
        wait_os(n);
        chk("ld_mid_new_period", n, 5);

        // Load on the wrap cycle: applies one period later
        step(4);
        div_int = 16'd2; div_load = 1'b1;
        step(1);
        chk("ld_wrap_tick", os_tick, 1'b1);
        div_load = 1'b0;
        wait_os(n);
        chk("ld_wrap_old_period", n, 5);
        wait_os(n);
        chk("ld_wrap_new_period", n, 2);

        // Phase resync two cycles after a tick
        load_idle(16'd3, 4'd0);
        en = 1'b1;
        wait_os(n);
        chk("sync_start", n, 3);
        step(1);
        sync_clr = 1'b1;
        step(1);
        chk("sync_no_tick", os_tick, 1'b0);
        sync_clr = 1'b0;
        wait_os(n);
        chk("sync_next", n, 3);
        chk("sync_first_no_mid", mid_tick, 1'b0);
        wait_os(n);
        chk("sync_second_gap", n, 3);
        chk("sync_second_mid", mid_tick, 1'b1);

        // Resync on a would-be wrap cycle wins
        step(2);
        sync_clr = 1'b1;
        step(1);
        chk("sync_prio_no_tick", os_tick, 1'b0);
        sync_clr = 1'b0;
        wait_os(n);
        chk("sync_prio_next", n, 3);

        // Load zero divisor while running, then recover with 4
        div_int = 16'd0; div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        wait_os(n);
        step(2);
        chk("zero_load_cfg_err", cfg_err, 1'b1);
        count_ticks(12, c);
        chk("zero_load_ticks", c, 0);
        div_int = 16'd4; div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        step(1);
        chk("recover_cfg_err", cfg_err, 1'b0);
        wait_os(n);
        chk("recover_first", n, 4);
        wait_os(n);
        chk("recover_gap", n, 4);

        // Drop enable on a would-be wrap cycle
        step(3);
        en = 1'b0;
        step(1);
        chk("en_off_no_tick", os_tick, 1'b0);
        count_ticks(8, c);
        chk("en_off_ticks", c, 0);
        en = 1'b1;
        wait_os(n);
        chk("en_restart", n, 4);

        // Asynchronous reset while os_tick is high
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_os", os_tick, 1'b0);
        chk("rst_async_bit", bit_tick, 1'b0);
        chk("rst_async_mid", mid_tick, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("rst_after_cfg_err", cfg_err, 1'b1);
        count_ticks(10, c);
        chk("rst_after_ticks", c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
